// File: rtl/residual_engine_pkg.sv
// Shared definitions for the residual engine: default geometry, FSM state
// encoding and the signed saturation helper.
package residual_engine_pkg;

  localparam int DEF_W    = 20;
  localparam int DEF_FRAC = 10;
  localparam int DEF_AW   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clamp a signed value into the w-bit two's complement range (w <= 63).
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/residual_engine_ram.sv
// Residual store: one write port and one registered read port that holds its
// value while no read is requested; same-address read returns the old word.
module residual_ram
  import residual_engine_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [2**AW];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/residual_engine.sv
// Linear-fit residual engine: e = b0 + x*b1 - y per sample, stored by sample
// index through a two-stage pipeline and summed into err_sum.
module residual_engine
  import residual_engine_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC,
  parameter int AW   = DEF_AW,
  parameter int SAT  = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [AW-1:0]   i_n_samples,
  input  logic [W-1:0]    i_b0,
  input  logic [W-1:0]    i_b1,
  input  logic [W-1:0]    i_x_in,
  input  logic [W-1:0]    i_y_in,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic            i_rd_en,
  input  logic [AW-1:0]   i_rd_addr,
  output logic [W-1:0]    o_rd_data,
  output logic            o_busy,
  output logic            o_done,
  output logic [W+AW-1:0] o_err_sum
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]            r_state;
  logic [AW-1:0]         r_count;
  logic [AW-1:0]         r_n;
  logic signed [W-1:0]   r_b0;
  logic signed [W-1:0]   r_b1;
  logic signed [W-1:0]   r_s1_x;
  logic signed [W-1:0]   r_s1_y;
  logic [AW-1:0]         r_s1_idx;
  logic                  r_s1_valid;
  logic [W-1:0]          r_s2_e;
  logic [AW-1:0]         r_s2_idx;
  logic                  r_s2_valid;
  logic [W+AW-1:0]       r_err_sum;

  logic                  w_xfer;
  logic signed [2*W-1:0] w_prod;
  logic signed [W+1:0]   w_slice_ext;
  logic signed [W+1:0]   w_e_wide;
  logic [W-1:0]          w_e;

  assign w_xfer = (r_state == S_RUN) && i_in_valid;

  // Shift left then arithmetic right isolates p[W+FRAC-1:FRAC] already sign-extended.
  assign w_prod      = r_s1_x * r_b1;
  assign w_slice_ext = (W+2)'((w_prod <<< (W - FRAC)) >>> W);
  assign w_e_wide    = {{2{r_b0[W-1]}}, r_b0} + w_slice_ext - {{2{r_s1_y[W-1]}}, r_s1_y};
  assign w_e         = (SAT != 0)
                     ? W'(sat_clip($signed({{(62-W){w_e_wide[W+1]}}, w_e_wide}), W))
                     : w_e_wide[W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_err_sum  <= '0;
    end else begin
      r_s1_valid <= w_xfer;
      r_s2_valid <= r_s1_valid;
      if (r_s2_valid) r_err_sum <= r_err_sum + {{AW{r_s2_e[W-1]}}, r_s2_e};
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_err_sum <= '0;
            r_count   <= '0;
            r_state   <= (i_n_samples != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_count <= r_count + AW'(1);
            if (r_count + AW'(1) == r_n) r_state <= S_DRAIN;
          end
        end
        // Leave once the last residual is being written and nothing trails it.
        S_DRAIN: if (r_s2_valid && !r_s1_valid) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && i_start) begin
      r_n  <= i_n_samples;
      r_b0 <= i_b0;
      r_b1 <= i_b1;
    end
    if (w_xfer) begin
      r_s1_x   <= i_x_in;
      r_s1_y   <= i_y_in;
      r_s1_idx <= r_count;
    end
    if (r_s1_valid) begin
      r_s2_e   <= w_e;
      r_s2_idx <= r_s1_idx;
    end
  end

  residual_ram #(.W(W), .AW(AW)) u_ram (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (r_s2_valid && !i_rst),
    .i_waddr  (r_s2_idx),
    .i_wdata  (r_s2_e),
    .i_rd_en  (i_rd_en),
    .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data)
  );

  assign o_in_ready = (r_state == S_RUN);
  assign o_busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done     = (r_state == S_DONE);
  assign o_err_sum  = r_err_sum;

endmodule

// File: tb/tb_residual_engine.sv
// Bench for residual_engine: wrapping and saturating instances driven in
// parallel and checked against an arithmetic model of the residual rules.
module tb_residual_engine;

  localparam int W    = 20;
  localparam int FRAC = 10;
  localparam int AW   = 8;
  localparam int EW   = W + AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] n_samples;
  logic [W-1:0]  b0, b1, x_in, y_in;
  logic          in_valid;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rdy_w, rdy_s, busy_w, busy_s, done_w, done_s;
  logic [W-1:0]  rd_w, rd_s;
  logic [EW-1:0] es_w, es_s;

  residual_engine #(.W(W), .FRAC(FRAC), .AW(AW), .SAT(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_n_samples(n_samples),
    .i_b0(b0), .i_b1(b1), .i_x_in(x_in), .i_y_in(y_in), .i_in_valid(in_valid),
    .o_in_ready(rdy_w), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_w),
    .o_busy(busy_w), .o_done(done_w), .o_err_sum(es_w)
  );

  residual_engine #(.W(W), .FRAC(FRAC), .AW(AW), .SAT(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_n_samples(n_samples),
    .i_b0(b0), .i_b1(b1), .i_x_in(x_in), .i_y_in(y_in), .i_in_valid(in_valid),
    .o_in_ready(rdy_s), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_s),
    .o_busy(busy_s), .o_done(done_s), .o_err_sum(es_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  name;
    longint b0, b1, x, y, ew, es;
  } vec_t;

  vec_t   tab[5];
  int     n_vec = 0;
  int     n_bad = 0;
  longint mw[256];
  longint ms[256];
  bit     kn[256];
  longint xq[$];
  longint yq[$];

  function automatic longint wrap_s(longint v, int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= (m >> 1)) r -= m;
    return r;
  endfunction

  function automatic longint clamp_s(longint v, int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // e = b0 + floor(x*b1 / 2^FRAC) (wrapped to W bits) - y, then wrap or clamp.
  function automatic longint resid(longint pb0, longint pb1, longint x, longint y, bit sat);
    longint p, d, q, e;
    p = x * pb1;
    d = longint'(1) << FRAC;
    q = p / d;
    if ((p % d != 0) && (p < 0)) q -= 1;
    e = pb0 + wrap_s(q, W) - y;
    return sat ? clamp_s(e, W) : wrap_s(e, W);
  endfunction

  function automatic longint rnd_w();
    if ($urandom_range(0, 1) == 1) return wrap_s(longint'($urandom), W);
    return longint'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    xq.delete();
    yq.delete();
    repeat (n) begin
      xq.push_back(rnd_w());
      yq.push_back(rnd_w());
    end
  endtask

  task automatic rd_vals(input int a, output longint vw, output longint vs);
    rd_en   = 1'b1;
    rd_addr = a[AW-1:0];
    step();
    rd_en = 1'b0;
    vw = wrap_s(longint'(rd_w), W);
    vs = wrap_s(longint'(rd_s), W);
  endtask

  task automatic rd_chk(input int a);
    longint vw, vs;
    rd_vals(a, vw, vs);
    chk($sformatf("rd_wrap[%0d]", a), vw, mw[a]);
    chk($sformatf("rd_sat[%0d]", a), vs, ms[a]);
    rd_addr = rd_addr + 1'b1;
    step();
    chk($sformatf("rd_hold[%0d]", a), wrap_s(longint'(rd_w), W), mw[a]);
  endtask

  // mode 0: in_valid always 1, 1: random gaps, 2: pattern 1,0,1,1,0,1
  task automatic do_run(input int n, input longint pb0, input longint pb1, input int mode);
    int       sent, cyc, pat, k;
    bit       v;
    bit [5:0] pv;
    longint   sumw, sums, ew, es, tx, ty;
    pv = 6'b101101;
    sent = 0; cyc = 0; pat = 0; sumw = 0; sums = 0;
    start = 1'b1;
    n_samples = n[AW-1:0];
    b0 = pb0[W-1:0];
    b1 = pb1[W-1:0];
    step();
    start = 1'b0;
    if (n == 0) begin
      chk("empty_done_w", longint'(done_w), 1);
      chk("empty_done_s", longint'(done_s), 1);
      chk("empty_busy", longint'(busy_w), 0);
      chk("empty_err_w", longint'(es_w), 0);
      chk("empty_err_s", longint'(es_s), 0);
      step();
      chk("empty_done_end", longint'(done_w), 0);
      if (kn[0]) rd_chk(0);
      return;
    end
    chk("run_busy", longint'(busy_w), 1);
    chk("run_err_clr", longint'(es_w), 0);
    while (sent < n && cyc < n * 8 + 20) begin
      chk("in_ready_run_w", longint'(rdy_w), 1);
      chk("in_ready_run_s", longint'(rdy_s), 1);
      v = (mode == 0) ? 1'b1 : ((mode == 2) ? pv[pat % 6] : 1'($urandom_range(0, 1)));
      tx = xq[sent];
      ty = yq[sent];
      in_valid  = v;
      x_in      = tx[W-1:0];
      y_in      = ty[W-1:0];
      start     = ($urandom_range(0, 3) == 0);
      n_samples = AW'($urandom);
      step();
      pat++;
      cyc++;
      if (v) begin
        ew = resid(pb0, pb1, tx, ty, 1'b0);
        es = resid(pb0, pb1, tx, ty, 1'b1);
        mw[sent] = ew;
        ms[sent] = es;
        kn[sent] = 1'b1;
        sumw += ew;
        sums += es;
        sent++;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (sent < n) chk("xfer_timeout", sent, n);
    chk("drain_ready_w", longint'(rdy_w), 0);
    chk("drain_ready_s", longint'(rdy_s), 0);
    chk("drain_busy", longint'(busy_w), 1);
    k = 0;
    do begin
      step();
      k++;
    end while (!done_w && k < 10);
    chk("done_latency", k, 2);
    chk("done_sat", longint'(done_s), 1);
    chk("done_busy", longint'(busy_w), 0);
    chk("err_sum_w", wrap_s(longint'(es_w), EW), wrap_s(sumw, EW));
    chk("err_sum_s", wrap_s(longint'(es_s), EW), wrap_s(sums, EW));
    step();
    chk("done_pulse_end", longint'(done_w), 0);
    chk("err_sum_stable", wrap_s(longint'(es_w), EW), wrap_s(sumw, EW));
    for (int a = 0; a <= n && a < 256; a++) begin
      if (kn[a]) rd_chk(a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint vw, vs;
    int     pulses;
    tab[0] = '{"basic",    512,      1024, 2048,  1024, 1536,                   1536};
    tab[1] = '{"ovf_pos",  'h7FFFF,  1024, 1024, -1024, wrap_s('h807FF, W),     524287};
    tab[2] = '{"ovf_neg",  -524288,  1024, -1024, 1024, 522240,                 -524288};
    tab[3] = '{"frac_pos", 0,        1536, 3,     0,    4,                      4};
    tab[4] = '{"frac_neg", 0,        1536, -3,    0,    -5,                     -5};
    for (int a = 0; a < 256; a++) kn[a] = 1'b0;

    rst = 1'b1; start = 1'b0; n_samples = '0; b0 = '0; b1 = '0;
    x_in = '0; y_in = '0; in_valid = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) step();
    chk("rst_ready", longint'(rdy_w), 0);
    chk("rst_busy", longint'(busy_w), 0);
    chk("rst_done", longint'(done_s), 0);
    chk("rst_err", longint'(es_w), 0);
    chk("rst_rd", longint'(rd_s), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      xq.delete(); yq.delete();
      xq.push_back(tab[i].x);
      yq.push_back(tab[i].y);
      do_run(1, tab[i].b0, tab[i].b1, 0);
      rd_vals(0, vw, vs);
      chk({tab[i].name, "_wrap"}, vw, tab[i].ew);
      chk({tab[i].name, "_sat"}, vs, tab[i].es);
    end

    // Read of the address being written returns the old word, then the new one.
    start = 1'b1; n_samples = 8'd1; b0 = 20'd100; b1 = '0;
    step();
    start = 1'b0; in_valid = 1'b1; x_in = '0; y_in = '0;
    step();
    in_valid = 1'b0;
    step();
    rd_en = 1'b1; rd_addr = '0;
    step();
    chk("coll_old_w", wrap_s(longint'(rd_w), W), mw[0]);
    chk("coll_old_s", wrap_s(longint'(rd_s), W), ms[0]);
    chk("coll_done", longint'(done_w), 1);
    step();
    chk("coll_new_w", wrap_s(longint'(rd_w), W), 100);
    chk("coll_new_s", wrap_s(longint'(rd_s), W), 100);
    rd_en = 1'b0;
    mw[0] = 100; ms[0] = 100;

    do_run(0, 5, 5, 0);

    fill(5);
    do_run(5, rnd_w(), rnd_w(), 0);
    fill(4);
    do_run(4, rnd_w(), rnd_w(), 2);

    // Abort after two of five transfers; a start pulse mid-run is ignored.
    start = 1'b1; n_samples = 8'd5; b0 = 20'd7; b1 = 20'd1024;
    step();
    in_valid = 1'b1; x_in = 20'd3; y_in = 20'd1; start = 1'b1; n_samples = 8'd1;
    step();
    start = 1'b0;
    chk("midrun_busy", longint'(busy_w), 1);
    chk("midrun_ready", longint'(rdy_w), 1);
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy_w", longint'(busy_w), 0);
    chk("abort_busy_s", longint'(busy_s), 0);
    chk("abort_ready", longint'(rdy_w), 0);
    chk("abort_err", longint'(es_w), 0);
    chk("abort_rd", longint'(rd_w), 0);
    pulses = 0;
    repeat (6) begin
      step();
      pulses += int'(done_w) + int'(done_s) + int'(busy_w);
    end
    chk("abort_no_done", pulses, 0);
    for (int a = 0; a < 5; a++) kn[a] = 1'b0;

    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 20);
      fill(n);
      do_run(n, rnd_w(), rnd_w(), $urandom_range(0, 1));
    end
    fill(255);
    do_run(255, rnd_w(), rnd_w(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
